apb_slave_mem: RTL and testbench



---
 rtl/apb_slave_mem.sv | 141 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with a word-addressed register memory.
// Optional wait-state insertion is compiled in when APB_SLV_WAIT_EN is defined;
// otherwise every transfer is zero-wait and WAIT_CYCLES is ignored.
module apb_slave_mem #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  pready_d;
    logic [DATA_WIDTH-1:0] prdata_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      paddr_idx;

    assign paddr_idx = PADDR[2 +: IDX_W];

`ifdef APB_SLV_WAIT_EN
    localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_bits;
    assign unused_bits = ^{PADDR[1:0], PADDR[ADDR_WIDTH-1:2+IDX_W]};
`else
    localparam logic ZERO_WAIT = 1'b1;
    logic             unused_bits;
    assign unused_bits = ^{PADDR[1:0], PADDR[ADDR_WIDTH-1:2+IDX_W], CNT_W'(WAIT_CYCLES)};
`endif

    // Next-state and next-output decode for the setup/access handshake
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        pready_d = PREADY;
        prdata_d = PRDATA;
        mem_we   = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // PENABLE=1 without a preceding setup phase is ignored
                if (PSEL && !PENABLE) begin
                    idx_d   = paddr_idx;
                    wr_d    = PWRITE;
                    state_d = ACCESS;
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = CNT_W'(WAIT_CYCLES);
`endif
                    if (ZERO_WAIT) begin
                        pready_d = 1'b1;
                        if (!PWRITE) begin
                            prdata_d = mem[paddr_idx];
                        end
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Master abort: drop the transfer, keep PRDATA
                    state_d  = IDLE;
                    pready_d = 1'b0;
                end else if (PREADY) begin
                    if (PENABLE) begin
                        mem_we   = wr_q;
                        pready_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
`ifdef APB_SLV_WAIT_EN
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pready_d = 1'b1;
                        if (!wr_q) begin
                            prdata_d = mem[idx_q];
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            PREADY  <= pready_d;
            PRDATA  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Register memory, cleared on reset, written on a completing write
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[idx_q] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem.
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
    localparam int EW  = 2;
    localparam int EW5 = 5;
`else
    localparam int EW  = 0;
    localparam int EW5 = 0;
`endif

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic        psel5, penable5;
    logic [31:0] prdata5;
    logic        pready5;

    int n_checks = 0;
    int n_errors = 0;

    apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    apb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(5)) dut5 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel5), .PENABLE(penable5),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata5), .PREADY(pready5)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic bus_idle();
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // One transfer on the main DUT; ends at the negedge of the PREADY cycle
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int cycles);
        @(negedge PCLK);
        n_checks++;
        if (PREADY !== 1'b0) begin
            n_errors++;
            $display("FAIL pready_at_setup: got %b want 0", PREADY);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        cycles = 2;
        while (PREADY !== 1'b1 && cycles < 40) begin
            @(negedge PCLK);
            cycles++;
        end
        if (PREADY !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout: addr %h PREADY=%b after %0d cycles", addr, PREADY, cycles);
        end
        rdata = PRDATA;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        psel5 = 1'b0; penable5 = 1'b0;
        #1;
        n_checks++;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: PREADY=%b PRDATA=%h want 0/0", PREADY, PRDATA);
        end
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int cyc;
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, rd, cyc);
        n_checks++;
        if (cyc !== 2 + EW) begin
            n_errors++;
            $display("FAIL wr_cycles: got %0d want %0d", cyc, 2 + EW);
        end
        bus_idle();
        xfer(1'b0, 32'h08, 32'h0, rd, cyc);
        n_checks++;
        if (cyc !== 2 + EW) begin
            n_errors++;
            $display("FAIL rd_cycles: got %0d want %0d", cyc, 2 + EW);
        end
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL rd_data: got %h want deadbeef", rd);
        end
        bus_idle();
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int cyc;
        xfer(1'b1, 32'h44, 32'h1234_5678, rd, cyc);
        bus_idle();
        xfer(1'b0, 32'h04, 32'h0, rd, cyc);
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL alias_data: got %h want 12345678", rd);
        end
        bus_idle();
        // Byte-offset bits are ignored too
        xfer(1'b0, 32'h0B, 32'h0, rd, cyc);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL byte_offset_data: got %h want deadbeef", rd);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int cyc;
        xfer(1'b1, 32'h0C, 32'hA5A5_0C0C, rd, cyc);
        bus_idle();
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'hBADB_AD00;
        @(negedge PCLK);
        PENABLE = 1'b1;
        n_checks++;
        if (PREADY !== 1'(EW == 0)) begin
            n_errors++;
            $display("FAIL abort_access1_pready: got %b want %b", PREADY, 1'(EW == 0));
        end
`ifdef APB_SLV_WAIT_EN
        @(negedge PCLK);
        n_checks++;
        if (PREADY !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_access2_pready: got %b want 0", PREADY);
        end
`endif
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if (PREADY !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_after_pready: got %b want 0", PREADY);
        end
        xfer(1'b0, 32'h0C, 32'h0, rd, cyc);
        n_checks++;
        if (rd !== 32'hA5A5_0C0C) begin
            n_errors++;
            $display("FAIL abort_data: got %h want a5a50c0c", rd);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(i * 4), 32'(i + 1), rd, cyc);
            n_checks++;
            if (cyc !== 2 + EW) begin
                n_errors++;
                $display("FAIL b2b_wr_cycles[%0d]: got %0d want %0d", i, cyc, 2 + EW);
            end
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, rd, cyc);
            n_checks++;
            if (cyc !== 2 + EW) begin
                n_errors++;
                $display("FAIL b2b_rd_cycles[%0d]: got %0d want %0d", i, cyc, 2 + EW);
            end
            n_checks++;
            if (rd !== 32'(i + 1)) begin
                n_errors++;
                $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rd, 32'(i + 1));
            end
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int cyc;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h5555_AAAA;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        n_checks++;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: PREADY=%b PRDATA=%h want 0/0", PREADY, PRDATA);
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, rd, cyc);
            n_checks++;
            if (rd !== 32'h0) begin
                n_errors++;
                $display("FAIL post_reset_data[%0d]: got %h want 0", i, rd);
            end
        end
        bus_idle();
    endtask

    task automatic test_zero_wait();
        int cyc;
        logic first_ready;
        for (int t = 0; t < 2; t++) begin
            @(negedge PCLK);
            psel5 = 1'b1; penable5 = 1'b0; PWRITE = (t == 0);
            PADDR = 32'h14; PWDATA = 32'hCAFE_F00D;
            @(negedge PCLK);
            penable5 = 1'b1;
            first_ready = pready5;
            cyc = 2;
            while (pready5 !== 1'b1 && cyc < 40) begin
                @(negedge PCLK);
                cyc++;
            end
            n_checks++;
            if (cyc !== 2 + EW5 || first_ready !== 1'(EW5 == 0)) begin
                n_errors++;
                $display("FAIL zw_timing[%0d]: cycles %0d first_ready %b want %0d/%b",
                         t, cyc, first_ready, 2 + EW5, 1'(EW5 == 0));
            end
            if (t == 1) begin
                n_checks++;
                if (prdata5 !== 32'hCAFE_F00D) begin
                    n_errors++;
                    $display("FAIL zw_rd_data: got %h want cafef00d", prdata5);
                end
            end
            @(negedge PCLK);
            psel5 = 1'b0; penable5 = 1'b0;
            n_checks++;
            if (pready5 !== 1'b0) begin
                n_errors++;
                $display("FAIL zw_pready_pulse[%0d]: got %b want 0", t, pready5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
